// File: rtl/coproc_custom0_issue.sv
// ---------------------------------------------------------------------------
// coproc_custom0_issue
//
// Core-side issue/writeback bridge for the custom0 coprocessor.
//   - Accepts custom0 operations from the pipeline into a single request
//     register that drives the coprocessor request stream.
//   - Records the rd of every accepted operation in an in-order tag FIFO.
//   - Pairs each in-order coprocessor response with the rd at the FIFO head
//     and presents the pair on the register-file writeback port.
//
// Parameters
//   XLEN  : operand/result width
//   DEPTH : maximum outstanding operations (power of 2, >= 2)
//
// Ports
//   clk_i, rst_i                       clock, synchronous active-high reset
//   issue_req_i / issue_ack_o          pipeline issue handshake
//   issue_funct7_i, issue_funct3_i     instruction function fields
//   issue_rs1_i, issue_rs2_i           operands
//   issue_rd_i                         destination register
//   stream_req_bus_genfifo_*           request stream to the coprocessor,
//                                      wdata = {funct7, funct3, rs1, rs2}
//   stream_resp_bus_genfifo_*          response stream from the coprocessor
//   wb_req_o / wb_ack_i                writeback handshake
//   wb_rd_o, wb_wdata_o                writeback destination and data
//   busy_o                             anything outstanding or pending
//   err_o                              sticky protocol error (reset clears)
//
// Optional feature
//   COPROC_CUSTOM0_TIMEOUT_EN : when defined, a 16-bit watchdog runs while
//   operations are outstanding and sets err_o on reaching 16'hFFFF.
// ---------------------------------------------------------------------------
module coproc_custom0_issue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_req_i,
  output logic                 issue_ack_o,
  input  logic [6:0]           issue_funct7_i,
  input  logic [2:0]           issue_funct3_i,
  input  logic [XLEN-1:0]      issue_rs1_i,
  input  logic [XLEN-1:0]      issue_rs2_i,
  input  logic [4:0]           issue_rd_i,
  output logic                 stream_req_bus_genfifo_req_o,
  output logic [10+2*XLEN-1:0] stream_req_bus_genfifo_wdata_bo,
  input  logic                 stream_req_bus_genfifo_ack_i,
  input  logic                 stream_resp_bus_genfifo_req_i,
  input  logic [XLEN-1:0]      stream_resp_bus_genfifo_rdata_bi,
  output logic                 stream_resp_bus_genfifo_ack_o,
  output logic                 wb_req_o,
  output logic [4:0]           wb_rd_o,
  output logic [XLEN-1:0]      wb_wdata_o,
  input  logic                 wb_ack_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = 10 + 2 * XLEN;

  logic          req_valid_q;
  logic [RW-1:0] req_data_q;

  logic [4:0]    tag_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic          tag_empty;
  logic          tag_full;

  logic          wb_valid_q;
  logic [4:0]    wb_rd_q;
  logic [XLEN-1:0] wb_wdata_q;

  logic          err_q;
  logic          tmo_hit;

  logic          issue_fire;
  logic          req_fire;
  logic          resp_fire;
  logic          tag_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign tag_empty = (wr_ptr_q == rd_ptr_q);
  assign tag_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Issue side never looks at wb_ack_i, so no combinational path from the
  // register file reaches the pipeline handshake.
  assign issue_ack_o = issue_req_i && !req_valid_q && !tag_full;
  assign issue_fire  = issue_ack_o;
  assign req_fire    = req_valid_q && stream_req_bus_genfifo_ack_i;

  // A response is taken whenever the writeback slot is free or is being
  // drained this very cycle, giving one response per cycle under wb_ack_i.
  assign stream_resp_bus_genfifo_ack_o =
    stream_resp_bus_genfifo_req_i && (!wb_valid_q || wb_ack_i);
  assign resp_fire = stream_resp_bus_genfifo_ack_o;
  assign tag_pop   = resp_fire && !tag_empty;

  // ---- stage p0: request register -----------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
    end else if (issue_fire) begin
      req_valid_q <= 1'b1;
      req_data_q  <= {issue_funct7_i, issue_funct3_i, issue_rs1_i, issue_rs2_i};
    end else if (req_fire) begin
      req_valid_q <= 1'b0;
    end
  end

  // ---- tag FIFO -----------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (issue_fire) begin
      tag_mem[wr_ptr_q[AW-1:0]] <= issue_rd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (issue_fire) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (tag_pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // ---- stage p1: writeback register ---------------------------------------
  // Orphan responses leave rd/data untouched; only the valid may drain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_wdata_q <= '0;
    end else if (tag_pop) begin
      wb_valid_q <= 1'b1;
      wb_rd_q    <= tag_mem[rd_ptr_q[AW-1:0]];
      wb_wdata_q <= stream_resp_bus_genfifo_rdata_bi;
    end else if (wb_ack_i) begin
      wb_valid_q <= 1'b0;
    end
  end

`ifdef COPROC_CUSTOM0_TIMEOUT_EN
  // Watchdog: counts cycles without a response while anything is in flight.
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || tag_empty || resp_fire) begin
      tmo_cnt_q <= '0;
    end else if (tmo_cnt_q != 16'hFFFF) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign tmo_hit = (tmo_cnt_q == 16'hFFFF);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if ((resp_fire && tag_empty) || tmo_hit) begin
      err_q <= 1'b1;
    end
  end

  assign stream_req_bus_genfifo_req_o    = req_valid_q;
  assign stream_req_bus_genfifo_wdata_bo = req_data_q;
  assign wb_req_o   = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_wdata_o = wb_wdata_q;
  assign busy_o     = req_valid_q || !tag_empty || wb_valid_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_coproc_custom0_issue.sv
module tb_coproc_custom0_issue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int RW    = 10 + 2 * XLEN;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            issue_req = 1'b0;
  logic            issue_ack;
  logic [6:0]      f7 = '0;
  logic [2:0]      f3 = '0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic [4:0]      rd = '0;
  logic            req_o;
  logic [RW-1:0]   wdata;
  logic            req_ack = 1'b0;
  logic            resp_req = 1'b0;
  logic [XLEN-1:0] rdata = '0;
  logic            resp_ack;
  logic            wb_req;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_wdata;
  logic            wb_ack = 1'b0;
  logic            busy;
  logic            err;

  always #5 clk = ~clk;

  coproc_custom0_issue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i                            (clk),
    .rst_i                            (rst),
    .issue_req_i                      (issue_req),
    .issue_ack_o                      (issue_ack),
    .issue_funct7_i                   (f7),
    .issue_funct3_i                   (f3),
    .issue_rs1_i                      (rs1),
    .issue_rs2_i                      (rs2),
    .issue_rd_i                       (rd),
    .stream_req_bus_genfifo_req_o     (req_o),
    .stream_req_bus_genfifo_wdata_bo  (wdata),
    .stream_req_bus_genfifo_ack_i     (req_ack),
    .stream_resp_bus_genfifo_req_i    (resp_req),
    .stream_resp_bus_genfifo_rdata_bi (rdata),
    .stream_resp_bus_genfifo_ack_o    (resp_ack),
    .wb_req_o                         (wb_req),
    .wb_rd_o                          (wb_rd),
    .wb_wdata_o                       (wb_wdata),
    .wb_ack_i                         (wb_ack),
    .busy_o                           (busy),
    .err_o                            (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: pending request, queue of outstanding rds,
  // writeback slot and sticky error.
  bit              m_req_v;
  logic [RW-1:0]   m_req_d;
  logic [4:0]      rdq[$];
  bit              m_wb_v;
  logic [4:0]      m_wb_rd;
  logic [XLEN-1:0] m_wb_d;
  bit              m_err;
  bit              last_ia;

  function automatic bit exp_issue_ack();
    return issue_req && !m_req_v && (rdq.size() < DEPTH);
  endfunction

  function automatic bit exp_resp_ack();
    return resp_req && (!m_wb_v || wb_ack);
  endfunction

  task automatic model_reset();
    m_req_v = 0; m_req_d = '0; rdq.delete();
    m_wb_v = 0; m_wb_rd = '0; m_wb_d = '0; m_err = 0;
  endtask

  // One clock: compare every output at the falling edge, then advance the
  // reference with the same inputs at the rising edge.
  task automatic cycle();
    bit ia, ra, rack;
    @(negedge clk);
    chk("issue_ack", issue_ack, exp_issue_ack());
    chk("resp_ack",  resp_ack,  exp_resp_ack());
    chk("req_o",     req_o,     m_req_v);
    chk("wdata",     wdata,     m_req_d);
    chk("wb_req",    wb_req,    m_wb_v);
    chk("wb_rd",     wb_rd,     m_wb_rd);
    chk("wb_wdata",  wb_wdata,  m_wb_d);
    chk("busy",      busy,      m_req_v || rdq.size() != 0 || m_wb_v);
    chk("err",       err,       m_err);
    ia = exp_issue_ack();
    ra = exp_resp_ack();
    rack = m_req_v && req_ack;
    @(posedge clk);
    last_ia = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (ra) begin
        if (rdq.size() > 0) begin
          m_wb_rd = rdq.pop_front();
          m_wb_d  = rdata;
          m_wb_v  = 1;
        end else begin
          m_err = 1;
          if (wb_ack) m_wb_v = 0;
        end
      end else if (wb_ack) begin
        m_wb_v = 0;
      end
      if (ia) begin
        m_req_v = 1;
        m_req_d = {f7, f3, rs1, rs2};
        rdq.push_back(rd);
      end else if (rack) begin
        m_req_v = 0;
      end
      last_ia = ia;
    end
    #1;
  endtask

  task automatic issue_op(input logic [2:0] fn3, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [4:0] d);
    int n;
    issue_req = 1; f7 = 7'h0B; f3 = fn3; rs1 = a; rs2 = b; rd = d;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_ia && n < 20);
    if (!last_ia) chk("issue_timeout", 0, 1);
    issue_req = 0;
  endtask

  task automatic drain();
    int n;
    issue_req = 0; req_ack = 1; wb_ack = 1;
    n = 0;
    while ((m_req_v || rdq.size() != 0 || m_wb_v) && n < 60) begin
      resp_req = (rdq.size() != 0) && !m_req_v;
      rdata = $urandom;
      cycle();
      n++;
    end
    resp_req = 0;
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    model_reset();
    // Reset state
    rst = 1;
    cycle(); cycle();
    rst = 0;
    cycle();
    chk("rst_wb_req", wb_req, 0);
    chk("rst_busy", busy, 0);

    // Single op
    issue_op(3'd1, 32'd5, 32'd7, 5'd3);
    chk("single_req_o", req_o, 1);
    req_ack = 1; cycle(); req_ack = 0;
    cycle();
    resp_req = 1; rdata = 32'd35; wb_ack = 1;
    cycle();
    resp_req = 0;
    chk("single_wb_req", wb_req, 1);
    chk("single_wb_rd", wb_rd, 5'd3);
    chk("single_wb_data", wb_wdata, 32'd35);
    cycle();
    chk("single_wb_done", wb_req, 0);
    chk("single_busy", busy, 0);

    // Fill the tag FIFO while holding responses
    req_ack = 1; wb_ack = 1;
    for (int k = 1; k <= 4; k++) begin
      issue_op(3'd2, XLEN'(k), XLEN'(k * 3), 5'(k));
      cycle();
    end
    issue_req = 1; rd = 5'd9; #1;
    chk("fill_full_ack", issue_ack, 0);
    cycle();
    issue_req = 0;
    for (int k = 1; k <= 4; k++) begin
      resp_req = 1; rdata = XLEN'(100 + k);
      cycle();
      chk("fill_wb_rd", wb_rd, 5'(k));
      chk("fill_wb_data", wb_wdata, XLEN'(100 + k));
    end
    resp_req = 0;
    cycle();

    // Request stall
    req_ack = 0;
    issue_op(3'd5, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7);
    issue_req = 1; rd = 5'd8;
    for (int k = 0; k < 5; k++) begin
      #1 chk("stall_ack", issue_ack, 0);
      chk("stall_wdata", wdata, {7'h0B, 3'd5, 32'hDEAD_BEEF, 32'h1234_5678});
      cycle();
    end
    req_ack = 1;
    cycle();
    chk("stall_reassert", issue_ack, 1);
    cycle();
    issue_req = 0;
    drain();

    // Writeback backpressure
    issue_op(3'd3, 32'd1, 32'd2, 5'd10);
    cycle();
    issue_op(3'd3, 32'd3, 32'd4, 5'd11);
    cycle();
    wb_ack = 0; resp_req = 1; rdata = 32'hA1;
    cycle();
    rdata = 32'hA2;
    #1 chk("bp_resp_ack_held", resp_ack, 0);
    cycle(); cycle();
    wb_ack = 1; #1;
    chk("bp_resp_ack_release", resp_ack, 1);
    cycle();
    resp_req = 0;
    chk("bp_second_rd", wb_rd, 5'd11);
    drain();

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      issue_req = ($urandom_range(0, 1) == 1);
      f7 = 7'($urandom); f3 = 3'($urandom);
      rs1 = $urandom; rs2 = $urandom; rd = 5'($urandom);
      req_ack = ($urandom_range(0, 9) < 6);
      resp_req = (rdq.size() != 0) && ($urandom_range(0, 1) == 1);
      rdata = $urandom;
      wb_ack = ($urandom_range(0, 9) < 7);
      cycle();
    end
    drain();

    // Orphan response
    resp_req = 1; rdata = 32'h55; #1;
    chk("orphan_ack", resp_ack, 1);
    cycle();
    resp_req = 0;
    chk("orphan_err", err, 1);
    chk("orphan_wb_req", wb_req, 0);
    cycle();

    // Reset mid-operation
    req_ack = 1; wb_ack = 0;
    for (int k = 0; k < 3; k++) begin
      issue_op(3'd4, XLEN'(k), XLEN'(k), 5'(20 + k));
      cycle();
    end
    resp_req = 1; rdata = 32'h77;
    cycle();
    resp_req = 0;
    chk("mid_wb_pending", wb_req, 1);
    rst = 1;
    cycle();
    rst = 0;
    chk("mid_req_o", req_o, 0);
    chk("mid_wdata", wdata, 0);
    chk("mid_wb_req", wb_req, 0);
    chk("mid_wb_rd", wb_rd, 0);
    chk("mid_wb_data", wb_wdata, 0);
    chk("mid_busy", busy, 0);
    chk("mid_err", err, 0);
    cycle();

`ifdef COPROC_CUSTOM0_TIMEOUT_EN
    // Watchdog: one outstanding op never answered
    req_ack = 1; wb_ack = 1;
    issue_op(3'd6, 32'd9, 32'd9, 5'd12);
    repeat (65000) @(posedge clk);
    #1 chk("tmo_early", err, 0);
    repeat (600) @(posedge clk);
    #1 chk("tmo_err", err, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
